fetch_stage: RTL and testbench

//  Instruction-fetch stage that sits directly upstream of the instruction memory.

---
 rtl/fetch_stage_if.sv | 17 +
 rtl/fetch_stage.sv | 102 ++++++++++
 tb/tb_fetch_stage.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and the instruction memory.
// The fetch stage presents a byte address; the memory answers with the word
// at that address in the same cycle.
interface fetch_stage_if;
  logic [31:0] mem_address;
  logic [31:0] mem_instr;

  modport master (
    output mem_address,
    input  mem_instr
  );

  modport slave (
    input  mem_address,
    output mem_instr
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory, and
// registers each returned word with its PC for the decoder. Stops on EBREAK,
// on running off the end of memory, or on a misaligned redirect target.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_RUN   | normal fetch, one word per unstalled cycle
// ST_HALT  | EBREAK seen or PC past end of memory; frozen until rst
// ST_ERROR | misaligned redirect target; frozen until rst
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          MEM_SIZE   = 256,
  parameter logic [31:0] HALT_INSTR = 32'h0010_0073
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_target,
  fetch_stage_if.master        imem,
  output logic [31:0]          instr_out,
  output logic [31:0]          pc_out,
  output logic                 instr_valid,
  output logic                 halted,
  output logic                 misaligned_err,
  output logic [31:0]          fetch_count
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_HALT  = 2'd1;
  localparam logic [1:0] ST_ERROR = 2'd2;

  // One bit wider than the PC so a memory of 2^30 words still compares correctly.
  localparam logic [32:0] MEM_LIMIT = 33'(MEM_SIZE) * 33'd4;

  logic [1:0]  state;
  logic [31:0] pc_reg;
  logic        pc_at_limit;
  logic        target_misaligned;

  assign imem.mem_address  = pc_reg;
  assign pc_at_limit       = ({1'b0, pc_reg} >= MEM_LIMIT);
  assign target_misaligned = (redirect_target[1:0] != 2'b00);

  // PC, IF output register, status flags and fetch counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_RUN;
      pc_reg         <= RESET_PC;
      instr_out      <= 32'h0;
      pc_out         <= 32'h0;
      instr_valid    <= 1'b0;
      halted         <= 1'b0;
      misaligned_err <= 1'b0;
      fetch_count    <= 32'h0;
    end else begin
      case (state)
        ST_RUN: begin
          if (redirect_valid && target_misaligned) begin
            state          <= ST_ERROR;
            misaligned_err <= 1'b1;
            halted         <= 1'b1;
            instr_valid    <= 1'b0;
          end else if (redirect_valid) begin
            // Flush: the word fetched from the old path this cycle is dropped.
            pc_reg      <= redirect_target;
            instr_valid <= 1'b0;
          end else if (stall) begin
            // Everything holds, including instr_valid.
          end else if (pc_at_limit) begin
            state       <= ST_HALT;
            halted      <= 1'b1;
            instr_valid <= 1'b0;
          end else begin
            instr_out   <= imem.mem_instr;
            pc_out      <= pc_reg;
            instr_valid <= 1'b1;
            pc_reg      <= pc_reg + 32'd4;
            if (fetch_count != 32'hFFFF_FFFF) begin
              fetch_count <= fetch_count + 32'd1;
            end
            // The EBREAK word itself still reaches the decoder; halted rises
            // on the following edge together with the valid drop.
            if (imem.mem_instr == HALT_INSTR) begin
              state <= ST_HALT;
            end
          end
        end
        ST_HALT, ST_ERROR: begin
          halted      <= 1'b1;
          instr_valid <= 1'b0;
        end
        default: begin
          state       <= ST_ERROR;
          halted      <= 1'b1;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a main instance (MEM_SIZE=256) walks through
// fetch, stall, redirect, EBREAK halt, end-of-memory and misaligned cases; a
// second instance (MEM_SIZE=4) checks the end-of-memory halt on a plain run.
module tb_fetch_stage;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  localparam logic [31:0] HALT_WORD = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] instr_out, pc_out, fetch_count;
  logic        instr_valid, halted, misaligned_err;

  logic        s_stall;
  logic        s_redirect_valid;
  logic [31:0] s_redirect_target;
  logic [31:0] s_instr_out, s_pc_out, s_fetch_count;
  logic        s_instr_valid, s_halted, s_misaligned_err;

  logic [31:0] mem [0:63];
  exp_t        sb [$];
  exp_t        s_sb [$];
  int          checks = 0;
  int          errors = 0;

  fetch_stage_if imem_bus ();
  fetch_stage_if s_bus ();

  // 100 MHz clock
  always #5 clk = ~clk;

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (a < 32'd256) return mem[a[7:2]];
    return 32'h0;
  endfunction

  assign imem_bus.mem_instr = rd(imem_bus.mem_address);
  assign s_bus.mem_instr    = rd(s_bus.mem_address);

  fetch_stage #(.RESET_PC(32'h0), .MEM_SIZE(256), .HALT_INSTR(HALT_WORD)) u_dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem            (imem_bus),
    .instr_out       (instr_out),
    .pc_out          (pc_out),
    .instr_valid     (instr_valid),
    .halted          (halted),
    .misaligned_err  (misaligned_err),
    .fetch_count     (fetch_count)
  );

  fetch_stage #(.RESET_PC(32'h0), .MEM_SIZE(4), .HALT_INSTR(HALT_WORD)) u_small (
    .clk             (clk),
    .rst             (rst),
    .stall           (s_stall),
    .redirect_valid  (s_redirect_valid),
    .redirect_target (s_redirect_target),
    .imem            (s_bus),
    .instr_out       (s_instr_out),
    .pc_out          (s_pc_out),
    .instr_valid     (s_instr_valid),
    .halted          (s_halted),
    .misaligned_err  (s_misaligned_err),
    .fetch_count     (s_fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic st, input logic rv, input logic [31:0] tg);
    stall           = st;
    redirect_valid  = rv;
    redirect_target = tg;
    @(posedge clk);
    #1;
  endtask

  task automatic push_main(input logic [31:0] a);
    exp_t e;
    e.instr = rd(a);
    e.pc    = a;
    sb.push_back(e);
  endtask

  task automatic push_small(input logic [31:0] a);
    exp_t e;
    e.instr = rd(a);
    e.pc    = a;
    s_sb.push_back(e);
  endtask

  task automatic pop_main(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_instr"}, instr_out, e.instr);
      chk({tag, "_pc"}, pc_out, e.pc);
      chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
    end
  endtask

  task automatic pop_small(input string tag);
    exp_t e;
    if (s_sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(s_sb.size()), 32'd1);
    end else begin
      e = s_sb.pop_front();
      chk({tag, "_instr"}, s_instr_out, e.instr);
      chk({tag, "_pc"}, s_pc_out, e.pc);
      chk({tag, "_valid"}, 32'(s_instr_valid), 32'd1);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = {16'hA5A5, 16'(i * 16'h0111)};
    mem[4] = HALT_WORD;

    s_stall = 1'b0; s_redirect_valid = 1'b0; s_redirect_target = 32'h0;
    rst = 1'b1;
    step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_mis", 32'(misaligned_err), 32'd0);
    chk("rst_count", fetch_count, 32'h0);
    chk("rst_addr", imem_bus.mem_address, 32'h0);
    rst = 1'b0;

    // Plain fetch of A, B
    push_main(32'h0); step(1'b0, 1'b0, 32'h0); pop_main("fetch_a");
    push_main(32'h4); step(1'b0, 1'b0, 32'h0); pop_main("fetch_b");

    // Three stalled cycles hold B
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'h0);
      chk("stall_instr", instr_out, rd(32'h4));
      chk("stall_pc", pc_out, 32'h4);
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_addr", imem_bus.mem_address, 32'h8);
      chk("stall_count", fetch_count, 32'd2);
    end

    push_main(32'h8); step(1'b0, 1'b0, 32'h0); pop_main("fetch_c");
    push_main(32'hC); step(1'b0, 1'b0, 32'h0); pop_main("fetch_d");
    chk("count_4", fetch_count, 32'd4);

    // Redirect beats stall
    step(1'b1, 1'b1, 32'h40);
    chk("redir_valid", 32'(instr_valid), 32'd0);
    chk("redir_addr", imem_bus.mem_address, 32'h40);
    push_main(32'h40); step(1'b0, 1'b0, 32'h0); pop_main("fetch_40");

    // EBREAK at 0x10
    step(1'b0, 1'b1, 32'h10);
    chk("redir10_addr", imem_bus.mem_address, 32'h10);
    push_main(32'h10); step(1'b0, 1'b0, 32'h0); pop_main("fetch_halt");
    chk("halt_not_yet", 32'(halted), 32'd0);
    step(1'b0, 1'b0, 32'h0);
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_valid", 32'(instr_valid), 32'd0);
    chk("halt_addr", imem_bus.mem_address, 32'h14);
    step(1'b0, 1'b1, 32'h0);
    chk("halt_redir_ignored", imem_bus.mem_address, 32'h14);
    chk("halt_pc_out", pc_out, 32'h10);
    chk("halt_count", fetch_count, 32'd6);

    // Reset out of HALT
    rst = 1'b1; step(1'b0, 1'b0, 32'h0); rst = 1'b0;
    chk("rst2_halted", 32'(halted), 32'd0);
    chk("rst2_addr", imem_bus.mem_address, 32'h0);

    // Redirect past the end of memory: halt on next unstalled edge
    step(1'b0, 1'b1, 32'h400);
    chk("far_addr", imem_bus.mem_address, 32'h400);
    chk("far_halted0", 32'(halted), 32'd0);
    step(1'b1, 1'b0, 32'h0);
    chk("far_stalled", 32'(halted), 32'd0);
    step(1'b0, 1'b0, 32'h0);
    chk("far_halted1", 32'(halted), 32'd1);
    chk("far_count", fetch_count, 32'd0);

    // Misaligned redirect
    rst = 1'b1; step(1'b0, 1'b0, 32'h0); rst = 1'b0;
    push_main(32'h0); step(1'b0, 1'b0, 32'h0); pop_main("mis_pre");
    step(1'b0, 1'b1, 32'h22);
    chk("mis_err", 32'(misaligned_err), 32'd1);
    chk("mis_halted", 32'(halted), 32'd1);
    chk("mis_valid", 32'(instr_valid), 32'd0);
    chk("mis_addr", imem_bus.mem_address, 32'h4);
    step(1'b0, 1'b1, 32'h8);
    chk("mis_frozen_addr", imem_bus.mem_address, 32'h4);
    chk("mis_count", fetch_count, 32'd1);

    // MEM_SIZE=4 instance: four words, then halt
    rst = 1'b1; step(1'b0, 1'b0, 32'h0); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_small(32'(i * 4));
      step(1'b0, 1'b0, 32'h0);
      pop_small("small_fetch");
    end
    step(1'b0, 1'b0, 32'h0);
    chk("small_halted", 32'(s_halted), 32'd1);
    chk("small_valid", 32'(s_instr_valid), 32'd0);
    chk("small_pc_out", s_pc_out, 32'hC);
    chk("small_count", s_fetch_count, 32'd4);

    chk("sb_drained", 32'(sb.size() + s_sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
